// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: byte-level bus between the SPI slave / board resources
// and the command sequencer.
//   slave  modport : sequencer side (takes SSEL/bytes/count, drives results)
//   master modport : environment side (drives SSEL/bytes/count, sees results)
// Signals: ssel_active, cmd[7:0], cmd_valid, count[COUNT_WIDTH-1:0],
//          count_clear, led_reg[7:0], response[7:0], busy, err_count[7:0]
interface spi_cmd_ctrl_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   ssel_active;
  logic [7:0]             cmd;
  logic                   cmd_valid;
  logic [COUNT_WIDTH-1:0] count;
  logic                   count_clear;
  logic [7:0]             led_reg;
  logic [7:0]             response;
  logic                   busy;
  logic [7:0]             err_count;

  modport slave (
    input  ssel_active, cmd, cmd_valid, count,
    output count_clear, led_reg, response, busy, err_count
  );

  modport master (
    output ssel_active, cmd, cmd_valid, count,
    input  count_clear, led_reg, response, busy, err_count
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: SPI command sequencer. Decodes host opcodes framed by SSEL,
// drives the response byte shifted out on the following transfer, owns the
// LED register, strobes the encoder-count clear and counts unknown opcodes.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - spi_cmd_ctrl_if.slave (ssel_active, cmd, cmd_valid, count in;
//          count_clear, led_reg, response, busy, err_count out)
// Opcodes: 00 NOP, 01 READ_COUNT (hi byte, then lo byte on next byte),
//          02 WRITE_LED (data on next byte), 03 CLEAR_COUNT, 04 READ_ERR.
// Optional build macro SPI_CMD_TIMEOUT_EN: abandons a multi-byte command
// after TIMEOUT_CYCLES without a byte, answering NAK and counting an error.
module spi_cmd_ctrl #(
  parameter int          COUNT_WIDTH    = 16,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter logic [7:0]  NAK_BYTE       = 8'hEE,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic           clk,
  input  logic           rst,
  spi_cmd_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LO   = 2'd1,
    WR_DATA = 2'd2
  } state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_RDCNT = 8'h01;
  localparam logic [7:0] OP_WRLED = 8'h02;
  localparam logic [7:0] OP_CLR   = 8'h03;
  localparam logic [7:0] OP_RDERR = 8'h04;

  state_t      state, state_d;
  logic [7:0]  resp_q, resp_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] snap_q, snap_d;
  logic        clr_q, clr_d;
  logic [15:0] count_ext;
  logic [7:0]  err_inc;
  logic        tmo_hit;

  always_comb begin
    count_ext = '0;
    count_ext[COUNT_WIDTH-1:0] = bus.count;
  end

  assign err_inc = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;

`ifdef SPI_CMD_TIMEOUT_EN
  logic [23:0] tmo_q;

  assign tmo_hit = (state != IDLE) && (tmo_q == TIMEOUT_CYCLES - 24'd1);

  // Restarts on every byte and whenever the FSM is (or is about to be) idle,
  // so it only measures the gap inside a multi-byte command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_q <= '0;
    else if (state == IDLE || bus.cmd_valid || state_d == IDLE)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + 24'd1;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state;
    resp_d  = resp_q;
    led_d   = led_q;
    err_d   = err_q;
    snap_d  = snap_q;
    clr_d   = 1'b0;
    if (!bus.ssel_active) begin
      // Frame ended: any byte arriving with it is dropped, partial command lost.
      state_d = IDLE;
      resp_d  = 8'h00;
    end else if (bus.cmd_valid) begin
      unique case (state)
        IDLE: begin
          unique case (bus.cmd)
            OP_NOP:   resp_d = 8'h00;
            OP_RDCNT: begin
              snap_d  = count_ext;
              resp_d  = count_ext[15:8];
              state_d = RD_LO;
            end
            OP_WRLED: begin
              resp_d  = ACK_BYTE;
              state_d = WR_DATA;
            end
            OP_CLR: begin
              // Gate on the current pulse so the strobe can never stretch
              // to two cycles even if bytes arrive on adjacent clocks.
              clr_d  = !clr_q;
              resp_d = ACK_BYTE;
            end
            OP_RDERR: resp_d = err_q;
            default: begin
              err_d  = err_inc;
              resp_d = NAK_BYTE;
            end
          endcase
        end
        RD_LO: begin
          // Low byte comes from the snapshot so hi/lo belong to one sample.
          resp_d  = snap_q[7:0];
          state_d = IDLE;
        end
        WR_DATA: begin
          led_d   = bus.cmd;
          resp_d  = bus.cmd;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
      resp_d  = NAK_BYTE;
      err_d   = err_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      resp_q <= 8'h00;
      led_q  <= 8'h00;
      err_q  <= 8'h00;
      snap_q <= 16'h0000;
      clr_q  <= 1'b0;
    end else begin
      state  <= state_d;
      resp_q <= resp_d;
      led_q  <= led_d;
      err_q  <= err_d;
      snap_q <= snap_d;
      clr_q  <= clr_d;
    end
  end

  // Registered alongside state so it equals (state != IDLE) exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.busy <= 1'b0;
    else     bus.busy <= (state_d != IDLE);
  end

  assign bus.response    = resp_q;
  assign bus.led_reg     = led_q;
  assign bus.err_count   = err_q;
  assign bus.count_clear = clr_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: scoreboard bench for spi_cmd_ctrl. Stimulus pushes the
// hand-computed result of each byte; a monitor pops and compares one cycle
// after every strobe. A second instance with COUNT_WIDTH=8 shares the byte
// stream and is checked on the READ_COUNT sequence.
module tb_spi_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ssel = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        cmd_valid = 1'b0;
  logic [15:0] cnt16 = 16'h0000;
  logic [7:0]  cnt8 = 8'h00;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic [7:0] resp;
    logic [7:0] led;
    logic [7:0] err;
    logic       busy;
    logic       clr;
    logic       chk8;
    logic [7:0] r8;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  spi_cmd_ctrl_if #(.COUNT_WIDTH(16)) bus16 ();
  spi_cmd_ctrl_if #(.COUNT_WIDTH(8))  bus8 ();

  assign bus16.ssel_active = ssel;
  assign bus16.cmd         = cmd;
  assign bus16.cmd_valid   = cmd_valid;
  assign bus16.count       = cnt16;
  assign bus8.ssel_active  = ssel;
  assign bus8.cmd          = cmd;
  assign bus8.cmd_valid    = cmd_valid;
  assign bus8.count        = cnt8;

  spi_cmd_ctrl #(.COUNT_WIDTH(16), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk (clk), .rst (rst), .bus (bus16.slave));
  spi_cmd_ctrl #(.COUNT_WIDTH(8), .TIMEOUT_CYCLES(24'd100)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8.slave));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Drive one byte strobe and queue what the DUT must show one cycle later.
  task automatic send(input logic [7:0] b, input logic [7:0] rsp, input logic [7:0] led,
                      input logic [7:0] err, input logic bsy, input logic clr,
                      input logic chk8 = 1'b0, input logic [7:0] r8 = 8'h00,
                      input logic s = 1'b1);
    exp_t e;
    @(posedge clk); #1;
    e.resp = rsp; e.led = led; e.err = err; e.busy = bsy; e.clr = clr;
    e.chk8 = chk8; e.r8 = r8;
    q.push_back(e);
    ssel = s; cmd = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (cmd_valid === 1'b1 && rst === 1'b0) begin
        @(negedge clk);
        if (q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_strobe: response %02h with empty scoreboard", bus16.response);
        end else begin
          e = q.pop_front();
          chk("response",    bus16.response, e.resp);
          chk("led_reg",     bus16.led_reg, e.led);
          chk("err_count",   bus16.err_count, e.err);
          chk("busy",        {7'd0, bus16.busy}, {7'd0, e.busy});
          chk("count_clear", {7'd0, bus16.count_clear}, {7'd0, e.clr});
          if (e.chk8) chk("response_w8", bus8.response, e.r8);
        end
      end
    end
  end

  task automatic clr_low_next;
    @(negedge clk); @(negedge clk);
    chk("clear_single_cycle", {7'd0, bus16.count_clear}, 8'h00);
  endtask

  initial begin
    logic [7:0] e_err;
    // Reset state
    #12;
    chk("rst_response", bus16.response, 8'h00);
    chk("rst_led",      bus16.led_reg, 8'h00);
    chk("rst_err",      bus16.err_count, 8'h00);
    chk("rst_busy",     {7'd0, bus16.busy}, 8'h00);
    chk("rst_clear",    {7'd0, bus16.count_clear}, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); ssel = 1'b1;

    // WRITE_LED
    send(8'h02, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b0);
    send(8'h3C, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);

    // READ_COUNT with count changing between bytes
    cnt16 = 16'h1234; cnt8 = 8'hAB;
    send(8'h01, 8'h12, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
    cnt16 = 16'h5678; cnt8 = 8'h11;
    send(8'hFF, 8'h34, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 8'hAB);

    // CLEAR_COUNT twice, 8 cycles apart
    send(8'h03, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b1);
    clr_low_next();
    repeat (5) @(posedge clk);
    send(8'h03, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b1);
    clr_low_next();

    // NOP, unknown opcodes, READ_ERR
    send(8'h00, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0);
    send(8'h77, 8'hEE, 8'h3C, 8'h01, 1'b0, 1'b0);
    send(8'h80, 8'hEE, 8'h3C, 8'h02, 1'b0, 1'b0);
    send(8'h04, 8'h02, 8'h3C, 8'h02, 1'b0, 1'b0);
    chk("err_count_2", bus16.err_count, 8'h02);

    // 300 bad opcodes saturate err_count
    for (int i = 0; i < 300; i++) begin
      e_err = (i + 3 > 255) ? 8'hFF : 8'(i + 3);
      send(8'hFF, 8'hEE, 8'h3C, e_err, 1'b0, 1'b0);
    end
    send(8'h04, 8'hFF, 8'h3C, 8'hFF, 1'b0, 1'b0);

    // SSEL drop coincident with the LED data byte
    send(8'h02, 8'hA5, 8'h3C, 8'hFF, 1'b1, 1'b0);
    send(8'h55, 8'h00, 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    ssel = 1'b1;

    // Async reset in the middle of RD_LO
    send(8'h01, 8'h56, 8'h3C, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_response", bus16.response, 8'h00);
    chk("async_rst_led",      bus16.led_reg, 8'h00);
    chk("async_rst_err",      bus16.err_count, 8'h00);
    chk("async_rst_busy",     {7'd0, bus16.busy}, 8'h00);
    @(negedge clk); rst = 1'b0;

    // Stalled READ_COUNT: timeout build abandons it, default build waits
    send(8'h01, 8'h56, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (150) @(posedge clk);
    @(negedge clk);
`ifdef SPI_CMD_TIMEOUT_EN
    chk("timeout_busy", {7'd0, bus16.busy}, 8'h00);
    chk("timeout_resp", bus16.response, 8'hEE);
    chk("timeout_err",  bus16.err_count, 8'h01);
`else
    chk("stall_busy", {7'd0, bus16.busy}, 8'h01);
    chk("stall_resp", bus16.response, 8'h56);
    chk("stall_err",  bus16.err_count, 8'h00);
`endif

    begin
      int n = 0;
      while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
      if (q.size() != 0) begin
        tot_cnt++;
        $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
